// File: rtl/sram_ctrl.sv
// Splits 32-bit LSU loads/stores into low/high halfword accesses on a 16-bit async SRAM.
// Ack after 1..2(WAIT_CYC+1)+1 cycles; o_ready low while busy, requests sampled only in IDLE.
module sram_ctrl #(
  parameter int ADDR_W   = 19,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_bmask,
  input  logic              i_wren,
  input  logic              i_rden,
  output logic              o_ready,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-2:0] o_sram_addr,
  output logic [15:0]       o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_in,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LO_SETUP, LO_ACC, HI_SETUP, HI_ACC, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-3:0]  waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         bmask_q, bmask_d;
  logic               wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rd_buf_q, rd_merge;
  logic               accept;

  logic               ce_d, we_d, oe_d, lb_d, ub_d, dqoe_d, hi_ph;
  logic [15:0]        dq_d;
  logic               cap, cap_hi;
  logic [1:0]         cap_lane;
  logic [15:0]        cap_half;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];
  assign o_ready = (state_q == IDLE);
  assign o_ack   = (state_q == DONE);

  // Captured request, seen one cycle early so the pin registers can follow state_d
  always_comb begin
    accept  = (state_q == IDLE) && (i_wren || i_rden);
    waddr_d = accept ? i_addr[ADDR_W-1:2] : waddr_q;
    wdata_d = accept ? i_wdata : wdata_q;
    bmask_d = accept ? i_bmask : bmask_q;
    wr_d    = accept ? i_wren  : wr_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_bmask == 4'b0000)  state_d = DONE;
          else if (|i_bmask[1:0])  state_d = i_wren ? LO_SETUP : LO_ACC;
          else                     state_d = i_wren ? HI_SETUP : HI_ACC;
        end
      end
      LO_SETUP: state_d = LO_ACC;
      LO_ACC: begin
        if (cnt_q == '0) begin
          if (|bmask_q[3:2]) state_d = wr_q ? HI_SETUP : HI_ACC;
          else               state_d = DONE;
        end
      end
      HI_SETUP: state_d = HI_ACC;
      HI_ACC:   if (cnt_q == '0) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin decode of the next state; registered so strobes are glitch-free
  always_comb begin
    hi_ph  = (state_d == HI_SETUP) || (state_d == HI_ACC);
    ce_d   = 1'b1;
    we_d   = 1'b1;
    oe_d   = 1'b1;
    lb_d   = 1'b1;
    ub_d   = 1'b1;
    dqoe_d = 1'b0;
    dq_d   = 16'h0000;
    if (state_d inside {LO_SETUP, LO_ACC, HI_SETUP, HI_ACC}) begin
      ce_d = 1'b0;
      lb_d = ~(hi_ph ? bmask_d[2] : bmask_d[0]);
      ub_d = ~(hi_ph ? bmask_d[3] : bmask_d[1]);
      dq_d = hi_ph ? wdata_d[31:16] : wdata_d[15:0];
      if (state_d == LO_SETUP || state_d == HI_SETUP) begin
        dqoe_d = 1'b1;
      end else if (wr_d) begin
        we_d   = 1'b0;
        dqoe_d = 1'b1;
      end else begin
        oe_d = 1'b0;
      end
    end
  end

  always_comb begin
    cap      = (state_q == LO_ACC || state_q == HI_ACC) && !wr_q && (cnt_q == '0);
    cap_hi   = (state_q == HI_ACC);
    cap_lane = cap_hi ? bmask_q[3:2] : bmask_q[1:0];
    cap_half = {i_sram_dq_in[15:8] & {8{cap_lane[1]}}, i_sram_dq_in[7:0] & {8{cap_lane[0]}}};
    rd_merge = rd_buf_q;
    if (cap) begin
      if (cap_hi) rd_merge[31:16] = cap_half;
      else        rd_merge[15:0]  = cap_half;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      waddr_q       <= '0;
      wdata_q       <= '0;
      bmask_q       <= '0;
      wr_q          <= 1'b0;
      cnt_q         <= '0;
      rd_buf_q      <= '0;
      o_rdata       <= '0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
      o_sram_dq_oe  <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_lb_n   <= 1'b1;
      o_sram_ub_n   <= 1'b1;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      wr_q     <= wr_d;
      rd_buf_q <= accept ? 32'h0 : rd_merge;
      if ((state_d == LO_ACC || state_d == HI_ACC) && state_d != state_q)
        cnt_q <= CNT_INIT;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      // Loads publish at DONE entry; a zero-mask load returns all zeros
      if (state_d == DONE && state_q != DONE) begin
        if (state_q == IDLE) begin
          if (!i_wren) o_rdata <= 32'h0;
        end else if (!wr_q) begin
          o_rdata <= rd_merge;
        end
      end
      o_sram_addr   <= {waddr_d, hi_ph};
      o_sram_dq_out <= dq_d;
      o_sram_dq_oe  <= dqoe_d;
      o_sram_ce_n   <= ce_d;
      o_sram_we_n   <= we_d;
      o_sram_oe_n   <= oe_d;
      o_sram_lb_n   <= lb_d;
      o_sram_ub_n   <= ub_d;
    end
  end

endmodule
